// File: rtl/countdown_timer_param.sv
// ---------------------------------------------------------------------------
// countdown_timer_param
//
// Parametrised countdown timer for timed waits in control FSMs. A reload
// value is counted down to zero, one step per Clock cycle, and termination is
// marked by a one-cycle done pulse. The timer can run once (one-shot) or
// restart itself from the reload value (periodic). It can also be paused,
// aborted, or given a new reload value while it runs.
//
// Parameters
//   WIDTH        counter / load-value width in bits (2..32)
//   DEFAULT_LOAD reload value after reset (0 <= DEFAULT_LOAD < 2**WIDTH)
//
// Ports
//   Clock       in   single clock, rising edge
//   Reset       in   asynchronous, active-high reset
//   load        in   capture load_value into reload and count, go idle
//   load_value  in   new reload value (WIDTH bits)
//   start       in   begin a countdown from the reload value
//   pause       in   level; freezes the count while high
//   abort       in   cancel the countdown, count <- reload, go idle
//   mode        in   0 = one-shot, 1 = periodic (sampled at the terminal step)
//   count       out  current count value (WIDTH bits)
//   busy        out  high while running or paused
//   done        out  one-cycle pulse when a countdown reaches zero
//   expired     out  level; high after a one-shot countdown finishes
//
// Command priority on each edge, highest first: load > abort > start > pause.
// All outputs come straight from flops, so no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module countdown_timer_param #(
    parameter int unsigned WIDTH        = 8,
    parameter logic [31:0] DEFAULT_LOAD = 32'd5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             expired
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] LOAD_RST = DEFAULT_LOAD[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] reload, reload_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             done_nxt;

    // Next-state decode. Only the highest-priority asserted command acts.
    // A start that arrives while running or paused has no effect, so the
    // normal run/pause behaviour proceeds underneath it.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // case/if tree leaves one unassigned and no latch is inferred.
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload;
        done_nxt   = 1'b0;

        if (load) begin
            // Cancels any countdown in flight without a done pulse.
            reload_nxt = load_value;
            count_nxt  = load_value;
            state_nxt  = IDLE;
        end else if (abort) begin
            count_nxt = reload;
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, EXPIRED: begin
                    // A zero reload would terminate immediately; refuse it.
                    if (start && (reload != '0)) begin
                        count_nxt = reload;
                        state_nxt = RUN;
                    end
                end

                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSE;
                    end else if (count == ONE) begin
                        // Terminal step: intercepting count == 1 (rather
                        // than decrementing to 0 first) keeps done aligned
                        // with count reaching 0 and means the counter can
                        // never wrap below zero.
                        done_nxt = 1'b1;
                        if (mode) begin
                            count_nxt = reload;
                        end else begin
                            count_nxt = '0;
                            state_nxt = EXPIRED;
                        end
                    end else begin
                        count_nxt = count - ONE;
                    end
                end

                PAUSE: begin
                    // Leaving PAUSE costs one edge with the count held.
                    if (!pause) begin
                        state_nxt = RUN;
                    end
                end

                default: state_nxt = IDLE;
            endcase
        end
    end

    // busy and expired are registered from the next state, so they change on
    // the same edge as the state they decode.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            reload  <= LOAD_RST;
            count   <= LOAD_RST;
            done    <= 1'b0;
            busy    <= 1'b0;
            expired <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all sequential state, so every
            // flop samples the pre-edge values regardless of statement order.
            state   <= state_nxt;
            reload  <= reload_nxt;
            count   <= count_nxt;
            done    <= done_nxt;
            busy    <= (state_nxt == RUN) || (state_nxt == PAUSE);
            expired <= (state_nxt == EXPIRED);
        end
    end

    // Structural invariants of the state encoding.
    a_busy_expired_exclusive : assert property (
        @(posedge Clock) disable iff (Reset) !(busy && expired)
    );

    a_expired_holds_zero : assert property (
        @(posedge Clock) disable iff (Reset) expired |-> (count == '0)
    );

endmodule

// File: tb/tb_countdown_timer_param.sv
// Bench for countdown_timer_param (WIDTH = 8, DEFAULT_LOAD = 5).
// Directed vectors carry hand-computed outputs for the cycle after each edge;
// the stimulus pushes them into a scoreboard queue and a separate monitor pops
// and compares them shortly after every rising edge.
module tb_countdown_timer_param;

    localparam int W = 8;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         load;
    logic [W-1:0] load_value;
    logic         start;
    logic         pause;
    logic         abort;
    logic         mode;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         expired;

    typedef struct packed {
        logic [W-1:0] count;
        logic         busy;
        logic         done;
        logic         expired;
    } obs_t;

    typedef struct {
        obs_t  exp;
        string tag;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        n_total  = 0;
    int        n_passed = 0;

    countdown_timer_param #(.WIDTH(W), .DEFAULT_LOAD(32'd5)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .mode       (mode),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .expired    (expired)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.count   = count;
        o.busy    = busy;
        o.done    = done;
        o.expired = expired;
        return o;
    endfunction

    // Monitor: one expectation per rising edge, compared 1 time unit later.
    always @(posedge Clock) begin
        #1;
        if (sb.size() != 0) begin
            sb_entry_t e;
            e = sb.pop_front();
            check(e.tag, 32'(observe()), 32'(e.exp));
        end
    end

    // One cycle of stimulus, called at a falling edge: drive inputs, push the
    // outputs expected after the next rising edge, return at the next falling edge.
    task automatic cyc(input string tag,
                       input logic ld, input logic [W-1:0] lv, input logic st,
                       input logic pa, input logic ab, input logic md,
                       input logic [W-1:0] ec, input logic eb,
                       input logic ed, input logic ee);
        sb_entry_t e;
        load = ld; load_value = lv; start = st; pause = pa; abort = ab; mode = md;
        e.exp.count = ec; e.exp.busy = eb; e.exp.done = ed; e.exp.expired = ee;
        e.tag = tag;
        sb.push_back(e);
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic idle(input string tag, input logic md,
                        input logic [W-1:0] ec, input logic eb,
                        input logic ed, input logic ee);
        cyc(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, md, ec, eb, ed, ee);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; load = 0; load_value = '0; start = 0; pause = 0; abort = 0; mode = 0;
        #12;
        check("reset_state", 32'(observe()), 32'(obs_t'{8'd5, 1'b0, 1'b0, 1'b0}));
        @(negedge Clock);
        Reset = 1'b0;

        // One-shot from DEFAULT_LOAD = 5.
        cyc ("os_start", 0, 0, 1, 0, 0, 0, 8'd5, 1, 0, 0);
        idle("os_4", 0, 8'd4, 1, 0, 0);
        idle("os_3", 0, 8'd3, 1, 0, 0);
        idle("os_2", 0, 8'd2, 1, 0, 0);
        idle("os_1", 0, 8'd1, 1, 0, 0);
        idle("os_done", 0, 8'd0, 0, 1, 1);
        idle("os_expired", 0, 8'd0, 0, 0, 1);

        // Periodic, reload 3.
        cyc ("per_load", 1, 8'd3, 0, 0, 0, 1, 8'd3, 0, 0, 0);
        cyc ("per_start", 0, 0, 1, 0, 0, 1, 8'd3, 1, 0, 0);
        for (int p = 0; p < 3; p++) begin
            idle("per_2", 1, 8'd2, 1, 0, 0);
            idle("per_1", 1, 8'd1, 1, 0, 0);
            idle("per_wrap", 1, 8'd3, 1, 1, 0);
        end
        idle("per_2_last", 1, 8'd2, 1, 0, 0);
        cyc ("per_abort", 0, 0, 0, 0, 1, 1, 8'd3, 0, 0, 0);

        // Periodic, reload 1: done high every cycle while running.
        cyc ("n1_load", 1, 8'd1, 0, 0, 0, 1, 8'd1, 0, 0, 0);
        cyc ("n1_start", 0, 0, 1, 0, 0, 1, 8'd1, 1, 0, 0);
        idle("n1_done_a", 1, 8'd1, 1, 1, 0);
        idle("n1_done_b", 1, 8'd1, 1, 1, 0);
        cyc ("n1_abort", 0, 0, 0, 0, 1, 1, 8'd1, 0, 0, 0);

        // Pause for 3 cycles at count 2, reload 4.
        cyc ("pz_load", 1, 8'd4, 0, 0, 0, 0, 8'd4, 0, 0, 0);
        cyc ("pz_start", 0, 0, 1, 0, 0, 0, 8'd4, 1, 0, 0);
        idle("pz_3", 0, 8'd3, 1, 0, 0);
        idle("pz_2", 0, 8'd2, 1, 0, 0);
        for (int p = 0; p < 3; p++)
            cyc("pz_hold", 0, 0, 0, 1, 0, 0, 8'd2, 1, 0, 0);
        idle("pz_resume", 0, 8'd2, 1, 0, 0);
        idle("pz_1", 0, 8'd1, 1, 0, 0);
        idle("pz_done", 0, 8'd0, 0, 1, 1);

        // Zero reload: start ignored.
        cyc ("z_load", 1, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 0);
        cyc ("z_start", 0, 0, 1, 0, 0, 0, 8'd0, 0, 0, 0);
        idle("z_idle", 0, 8'd0, 0, 0, 0);

        // load and start together: load wins, stays idle.
        cyc ("ls_both", 1, 8'd6, 1, 0, 0, 0, 8'd6, 0, 0, 0);
        idle("ls_idle", 0, 8'd6, 0, 0, 0);

        // Abort at count 3.
        cyc ("ab_start", 0, 0, 1, 0, 0, 0, 8'd6, 1, 0, 0);
        idle("ab_5", 0, 8'd5, 1, 0, 0);
        idle("ab_4", 0, 8'd4, 1, 0, 0);
        idle("ab_3", 0, 8'd3, 1, 0, 0);
        cyc ("ab_abort", 0, 0, 0, 0, 1, 0, 8'd6, 0, 0, 0);
        idle("ab_idle", 0, 8'd6, 0, 0, 0);

        // Abort + start on the terminal edge: abort wins, no done.
        cyc ("abt_start", 0, 0, 1, 0, 0, 0, 8'd6, 1, 0, 0);
        for (int c = 5; c >= 1; c--)
            idle("abt_cnt", 0, W'(c), 1, 0, 0);
        cyc ("abt_term", 0, 0, 1, 0, 1, 0, 8'd6, 0, 0, 0);
        idle("abt_nodone", 0, 8'd6, 0, 0, 0);

        // Asynchronous reset mid-count at count 2.
        cyc ("ar_start", 0, 0, 1, 0, 0, 0, 8'd6, 1, 0, 0);
        for (int c = 5; c >= 2; c--)
            idle("ar_cnt", 0, W'(c), 1, 0, 0);
        #2 Reset = 1'b1;
        #1 check("async_reset", 32'(observe()), 32'(obs_t'{8'd5, 1'b0, 1'b0, 1'b0}));
        @(negedge Clock);
        Reset = 1'b0;
        cyc ("ar_restart", 0, 0, 1, 0, 0, 0, 8'd5, 1, 0, 0);
        for (int c = 4; c >= 1; c--)
            idle("ar_run", 0, W'(c), 1, 0, 0);
        idle("ar_done", 0, 8'd0, 0, 1, 1);

        repeat (2) @(negedge Clock);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/countdown_timer_param.md
# countdown_timer_param

Parametrised countdown timer for the lab-2 control path. A reload value is counted down to zero one step per `Clock` cycle. Termination is signalled with a one-cycle `done` pulse. The block supports one-shot and auto-reload (periodic) modes, plus pause, abort and runtime reload of the start value. It replaces fixed-width, fixed-start countdown blocks in control FSMs that need timed waits.

## Interface
- `WIDTH`, default 8: counter and load-value width in bits; legal range 2–32.
- `DEFAULT_LOAD`, default 5: reload value after reset; must satisfy 0 ≤ DEFAULT_LOAD < 2^WIDTH.

- `Clock`  in  1: single clock; all state changes on its rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `load`  in  1: capture `load_value` into the reload register.
- `load_value`  in  WIDTH: new reload value.
- `start`  in  1: begin a countdown from the reload value.
- `pause`  in  1: level; freezes the count while high.
- `abort`  in  1: cancel the countdown and return to idle.
- `mode`  in  1: 0 = one-shot, 1 = periodic auto-reload.
- `count`  out  WIDTH: current count value.
- `busy`  out  1: high in RUN or PAUSE.
- `done`  out  1: one-cycle pulse when a countdown reaches zero.
- `expired`  out  1: level; high in EXPIRED.

## Operation
- Registers:
  - `reload` (WIDTH bits)
  - `count` (WIDTH bits)
  - state ∈ {IDLE, RUN, PAUSE, EXPIRED}
  - `done` flop
- Reset values: state IDLE, `reload` = `count` = DEFAULT_LOAD, `busy` = 0, `done` = 0, `expired` = 0.
- Input priority per edge, highest first: `load` > `abort` > `start` > `pause`.
  - Only the highest-priority asserted command acts.
- `load`, any state:
  - `reload` ← `load_value`, `count` ← `load_value`, state → IDLE.
  - A running countdown is cancelled with no `done` pulse.
- `abort`, any state: `count` ← `reload`, state → IDLE, no `done` pulse.
- `start`:
  - In IDLE or EXPIRED, with `reload` ≠ 0: `count` ← `reload`, state → RUN.
  - With `reload` == 0: ignored; state unchanged.
  - In RUN or PAUSE: ignored.
- RUN:
  - `pause` = 1 → PAUSE, `count` held.
  - Otherwise `count` decrements by 1.
- PAUSE: `pause` = 0 → RUN; `count` is held on this edge.
- Terminal step: in RUN with `count` == 1 and no higher-priority command.
  - `done` ← 1 for exactly the following cycle.
  - `mode` = 0: `count` ← 0, state → EXPIRED.
  - `mode` = 1: `count` ← `reload`, state stays RUN.
- `mode` is sampled only at the terminal step; changing it mid-count is legal.
- EXPIRED: holds `count` = 0 until `start`, `load` or `abort`.
- Arithmetic: the decrement is unsigned modulo 2^WIDTH. The counter never wraps below 0, because the terminal step intercepts `count` == 1.
- Outputs are registered, or decoded from registered state only; there are no combinational input-to-output paths.

## Timing
- Start latency:
  - `start` sampled at edge k with `reload` = N → `busy` high and `count` = N after edge k.
  - `count` = N−i after edge k+i.
  - `done` high during the cycle following edge k+N.
  - Total: N cycles from start to `done`, with no pauses.
- Each cycle spent in PAUSE delays `done` by one cycle. A one-cycle `pause` pulse costs 2 cycles: one edge to enter PAUSE and one edge to return to RUN.
- Periodic mode: `done` pulses every N cycles. With N = 1, `done` stays high every cycle while running.
- `done` is never high for two consecutive cycles unless `reload` == 1 in periodic mode.
- Asynchronous `Reset` mid-count forces all reset values immediately, independent of `Clock`. The first `start` is accepted on the first edge after `Reset` deasserts.
- `load` and `start` on the same edge: `load` wins, state → IDLE. A second `start` is required.
- `abort` on the terminal edge: `abort` wins, and no `done` pulse is produced.

## Test plan
- Reset, WIDTH = 8, DEFAULT_LOAD = 5, `mode` = 0:
  - `start` → `count` 5,4,3,2,1,0 on successive edges.
  - `done` high for exactly 1 cycle, coincident with `count` 0.
  - `expired` = 1 and `busy` = 0 afterwards.
- `load` with `load_value` = 3, `mode` = 1, `start`, run 10 cycles:
  - `count` 3,2,1,3,2,1,3,…
  - `done` pulses 3 cycles apart.
  - `busy` stays 1 throughout.
- `load` with `load_value` = 4, `start`, assert `pause` for 3 cycles at `count` = 2:
  - `count` holds 2 during the pause.
  - `done` arrives 4 cycles later than in the unpaused run.
- `load` with `load_value` = 0, then `start` → state stays IDLE, `busy` = 0, `done` never asserts.
- Abort cases, with `load_value` = 6 after `start`:
  - `abort` at `count` = 3 → IDLE, `count` = 6, no `done`.
  - Repeat, asserting `abort` and `start` together on the terminal edge → `abort` wins and no `done` pulse occurs.
- Assert `Reset` asynchronously, between `Clock` edges, mid-count at `count` = 2:
  - All outputs go to their reset values before the next edge (`count` = 5, `busy` = 0).
  - Deassert `Reset`; a subsequent `start` counts from 5 again.
